// File: rtl/cia_serial_port_pkg.sv
// ---------------------------------------------------------------------------
// cia_serial_port_pkg
// Shared definitions for the 6526-style serial port inside soc_65xx:
//   SP_DATA_W   - default shift register / SDR width
//   SP_MODE_IN  - CRA SPMODE value for input mode
//   SP_MODE_OUT - CRA SPMODE value for output mode
//   sp_state_t  - output-mode shift engine state encoding
// ---------------------------------------------------------------------------
package cia_serial_port_pkg;

    localparam int   SP_DATA_W   = 8;
    localparam logic SP_MODE_IN  = 1'b0;
    localparam logic SP_MODE_OUT = 1'b1;

    typedef enum logic {
        SP_IDLE  = 1'b0,
        SP_SHIFT = 1'b1
    } sp_state_t;

endpackage

// File: rtl/cia_sync_edge.sv
// ---------------------------------------------------------------------------
// cia_sync_edge
// Multi-stage synchroniser for an asynchronous pin plus a rising-edge
// detector on the synchronised level. All state advances on clk_en only.
//
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   clk_en      - peripheral clock enable
//   din         - asynchronous pin input
//   sync_level  - synchronised pin level (SYNC_STAGES clk_en cycles late)
//   rise        - one-clk_en-cycle pulse on an accepted 0->1 transition
//
// Configuration macro: CIA_SP_CNT_FILTER_EN
//   Defined   - a new level must be held for 3 consecutive clk_en cycles
//               before the edge is accepted (glitch rejection, +2 cycles).
//   Undefined - edges are taken directly from the synchroniser output.
// ---------------------------------------------------------------------------
module cia_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_en,
    input  logic din,
    output logic sync_level,
    output logic rise
);

    // Idle level of the CIA pins is high, so the chain resets to ones and no
    // false edge is seen when reset is released.
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else if (clk_en) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge value of its neighbours.
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign sync_level = sync_q[SYNC_STAGES-1];

`ifdef CIA_SP_CNT_FILTER_EN
    // flt_q is the last accepted level; hold_q counts consecutive cycles
    // that the synchronised level has differed from it.
    logic       flt_q;
    logic [1:0] hold_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            flt_q  <= 1'b1;
            hold_q <= 2'd0;
        end else if (clk_en) begin
            if (sync_level != flt_q) begin
                if (hold_q == 2'd2) begin
                    flt_q  <= sync_level;
                    hold_q <= 2'd0;
                end else begin
                    hold_q <= hold_q + 2'd1;
                end
            end else begin
                hold_q <= 2'd0;
            end
        end
    end

    // Accept on the third consecutive cycle at the new level.
    assign rise = sync_level && !flt_q && (hold_q == 2'd2);
`else
    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else if (clk_en) begin
            prev_q <= sync_level;
        end
    end

    assign rise = sync_level && !prev_q;
`endif

endmodule

// File: rtl/cia_serial_port.sv
// ---------------------------------------------------------------------------
// cia_serial_port
// Serial data register (SDR) and shift engine of the 6526-style peripheral.
//   Input mode  (sp_mode=0): shifts sp_in in on rising CNT edges, posts each
//                            completed byte to the SDR and pulses sp_irq.
//   Output mode (sp_mode=1): serialises CPU-written bytes MSB first on
//                            sp_out, toggling cnt_out on every Timer A
//                            underflow; pulses sp_irq after each byte.
//
// Ports:
//   clk, reset    - system clock, synchronous active-high reset
//   clk_en        - peripheral clock enable; state advances only when high
//   sp_mode       - CRA SPMODE (0 input, 1 output)
//   ta_underflow  - Timer A underflow pulse (output-mode bit clock)
//   sdr_wr/sdr_din- CPU write to SDR
//   sdr_dout      - SDR read value
//   sp_in, cnt_in - asynchronous serial data / CNT pins
//   sp_out,cnt_out- serial data / CNT pin drive
//   sp_irq        - one-clk_en-cycle pulse on byte complete
//   busy          - output-mode transfer in progress
//
// Configuration macro: CIA_SP_CNT_FILTER_EN (CNT glitch filter, implemented
// in cia_sync_edge; adds 2 clk_en cycles of input-mode latency).
// ---------------------------------------------------------------------------
module cia_serial_port
    import cia_serial_port_pkg::*;
#(
    parameter int DATA_W      = SP_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              sp_mode,
    input  logic              ta_underflow,
    input  logic              sdr_wr,
    input  logic [DATA_W-1:0] sdr_din,
    output logic [DATA_W-1:0] sdr_dout,
    input  logic              sp_in,
    input  logic              cnt_in,
    output logic              sp_out,
    output logic              cnt_out,
    output logic              sp_irq,
    output logic              busy
);

    localparam int              CNT_W     = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] BITS_LAST = CNT_W'(DATA_W - 1);

    // -----------------------------------------------------------------------
    // Pin synchronisers. The data pin only needs the synchronised level and
    // the CNT pin only needs the edge; the other outputs are left unused.
    // -----------------------------------------------------------------------
    logic sp_s;
    logic sp_rise_unused;
    logic cnt_rise;
    logic cnt_level_unused;

    cia_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sp_sync (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .din        (sp_in),
        .sync_level (sp_s),
        .rise       (sp_rise_unused)
    );

    cia_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cnt_sync (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .din        (cnt_in),
        .sync_level (cnt_level_unused),
        .rise       (cnt_rise)
    );

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    sp_state_t         state_q,   state_d;
    logic [DATA_W-1:0] shift_q,   shift_d;
    logic [DATA_W-1:0] sdr_q,     sdr_d;
    logic [CNT_W-1:0]  bits_q,    bits_d;
    logic              pending_q, pending_d;
    logic              sp_out_q,  sp_out_d;
    logic              cnt_out_q, cnt_out_d;
    logic              irq_q,     irq_d;
    logic              busy_q,    busy_d;
    logic              mode_q;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every next-state value is defaulted first so no path through
        // this block leaves a signal unassigned (which would infer a latch).
        state_d   = state_q;
        shift_d   = shift_q;
        sdr_d     = sdr_q;
        bits_d    = bits_q;
        pending_d = pending_q;
        sp_out_d  = sp_out_q;
        cnt_out_d = cnt_out_q;
        irq_d     = 1'b0;
        busy_d    = busy_q;

        if (sp_mode != mode_q) begin
            // Mode change aborts any transfer silently; SDR is kept.
            state_d   = SP_IDLE;
            bits_d    = '0;
            pending_d = 1'b0;
            cnt_out_d = 1'b1;
            sp_out_d  = 1'b1;
            busy_d    = 1'b0;
            if (sdr_wr) begin
                sdr_d = sdr_din;
            end
        end else if (sp_mode == SP_MODE_IN) begin
            state_d   = SP_IDLE;
            sp_out_d  = 1'b1;
            cnt_out_d = 1'b1;
            busy_d    = 1'b0;
            pending_d = 1'b0;
            if (sdr_wr) begin
                sdr_d = sdr_din;
            end
            if (cnt_rise) begin
                shift_d = {shift_q[DATA_W-2:0], sp_s};
                if (bits_q == BITS_LAST) begin
                    // A completed byte wins over a CPU write in the same cycle.
                    sdr_d  = {shift_q[DATA_W-2:0], sp_s};
                    irq_d  = 1'b1;
                    bits_d = '0;
                end else begin
                    bits_d = bits_q + 1'b1;
                end
            end
        end else begin
            if (sdr_wr) begin
                sdr_d     = sdr_din;
                pending_d = 1'b1;
            end
            if (ta_underflow) begin
                if (state_q == SP_IDLE) begin
                    if (pending_q) begin
                        // Load takes the pre-write SDR; a simultaneous write
                        // stays pending for the following byte.
                        shift_d   = sdr_q;
                        pending_d = sdr_wr;
                        sp_out_d  = sdr_q[DATA_W-1];
                        cnt_out_d = 1'b0;
                        bits_d    = '0;
                        busy_d    = 1'b1;
                        state_d   = SP_SHIFT;
                    end
                end else if (!cnt_out_q) begin
                    // Rising CNT: receiver samples the current bit here.
                    cnt_out_d = 1'b1;
                    if (bits_q == BITS_LAST) begin
                        irq_d   = 1'b1;
                        busy_d  = 1'b0;
                        bits_d  = '0;
                        state_d = SP_IDLE;
                    end else begin
                        bits_d = bits_q + 1'b1;
                    end
                end else begin
                    // Falling CNT: present the next bit, MSB first.
                    cnt_out_d = 1'b0;
                    shift_d   = {shift_q[DATA_W-2:0], 1'b0};
                    sp_out_d  = shift_q[DATA_W-2];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SP_IDLE;
            shift_q   <= '0;
            sdr_q     <= '0;
            bits_q    <= '0;
            pending_q <= 1'b0;
            sp_out_q  <= 1'b1;
            cnt_out_q <= 1'b1;
            irq_q     <= 1'b0;
            busy_q    <= 1'b0;
            // Track the live mode during reset so leaving reset is not
            // mistaken for a mode change.
            mode_q    <= sp_mode;
        end else if (clk_en) begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            sdr_q     <= sdr_d;
            bits_q    <= bits_d;
            pending_q <= pending_d;
            sp_out_q  <= sp_out_d;
            cnt_out_q <= cnt_out_d;
            irq_q     <= irq_d;
            busy_q    <= busy_d;
            mode_q    <= sp_mode;
        end
    end

    assign sdr_dout = sdr_q;
    assign sp_out   = sp_out_q;
    assign cnt_out  = cnt_out_q;
    assign sp_irq   = irq_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_cia_serial_port.sv
// ---------------------------------------------------------------------------
// tb_cia_serial_port
// Directed self-checking bench for cia_serial_port: reset state, input-mode
// byte reception and interrupt latency, CNT glitch handling, output-mode
// serialisation (single, back-to-back, write-during-load), mode-change abort
// and reset during a transfer.
// ---------------------------------------------------------------------------
module tb_cia_serial_port;
    import cia_serial_port_pkg::*;

    localparam int DATA_W = SP_DATA_W;
`ifdef CIA_SP_CNT_FILTER_EN
    localparam int IRQ_LAT = 5;
`else
    localparam int IRQ_LAT = 3;
`endif

    logic              clk          = 1'b0;
    logic              reset        = 1'b1;
    logic              clk_en       = 1'b1;
    logic              sp_mode      = SP_MODE_IN;
    logic              ta_underflow = 1'b0;
    logic              sdr_wr       = 1'b0;
    logic [DATA_W-1:0] sdr_din      = '0;
    logic              sp_in        = 1'b1;
    logic              cnt_in       = 1'b1;
    logic [DATA_W-1:0] sdr_dout;
    logic              sp_out;
    logic              cnt_out;
    logic              sp_irq;
    logic              busy;

    int checks = 0;
    int errors = 0;

    cia_serial_port dut (
        .clk          (clk),
        .reset        (reset),
        .clk_en       (clk_en),
        .sp_mode      (sp_mode),
        .ta_underflow (ta_underflow),
        .sdr_wr       (sdr_wr),
        .sdr_din      (sdr_din),
        .sdr_dout     (sdr_dout),
        .sp_in        (sp_in),
        .cnt_in       (cnt_in),
        .sp_out       (sp_out),
        .cnt_out      (cnt_out),
        .sp_irq       (sp_irq),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Line monitor on the falling edge: counts sp_irq cycles and captures
    // sp_out at each cnt_out rising edge, as an external receiver would.
    logic        prev_cnt = 1'b1;
    logic [15:0] rx_bits  = '0;
    int          rise_cnt = 0;
    int          irq_cnt  = 0;

    always @(negedge clk) begin
        if (sp_irq) irq_cnt <= irq_cnt + 1;
        if (cnt_out && !prev_cnt) begin
            rx_bits  <= {rx_bits[14:0], sp_out};
            rise_cnt <= rise_cnt + 1;
        end
        prev_cnt <= cnt_out;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_sdr(input logic [7:0] v);
        sdr_wr  = 1'b1;
        sdr_din = v;
        tick(1);
        sdr_wr  = 1'b0;
    endtask

    task automatic underflow(input int n);
        repeat (n) begin
            ta_underflow = 1'b1;
            tick(1);
            ta_underflow = 1'b0;
            tick(1);
        end
    endtask

    // Sends v[n-1:0] MSB first as CNT pulses; checks sp_irq latency after
    // the last rising edge.
    task automatic send_bits(input logic [7:0] v, input int n);
        for (int b = n - 1; b >= 0; b--) begin
            sp_in  = v[b];
            cnt_in = 1'b0;
            tick(4);
            cnt_in = 1'b1;
            if (b == 0) begin
                for (int i = 1; i <= IRQ_LAT + 1; i++) begin
                    tick(1);
                    check("in_irq_latency", 32'(sp_irq), 32'(i == IRQ_LAT));
                end
            end else begin
                tick(6);
            end
        end
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int irq_base;
        int rise_base;

        // ---------------- reset state ----------------
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_sdr",     32'(sdr_dout), 32'h00);
        check("rst_sp_out",  32'(sp_out),   32'h1);
        check("rst_cnt_out", 32'(cnt_out),  32'h1);
        check("rst_irq",     32'(sp_irq),   32'h0);
        check("rst_busy",    32'(busy),     32'h0);

        // ---------------- input mode ----------------
        clk_en = 1'b0;
        write_sdr(8'h11);
        clk_en = 1'b1;
        check("clk_en_gates_wr", 32'(sdr_dout), 32'h00);
        write_sdr(8'h5A);
        check("in_cpu_write", 32'(sdr_dout), 32'h5A);

        irq_base = irq_cnt;
        send_bits(8'hA5, 8);
        check("in_byte_a5",   32'(sdr_dout),       32'hA5);
        check("in_irq_count", 32'(irq_cnt - irq_base), 32'd1);
        check("in_out_idle",  32'({sp_out, cnt_out}), 32'h3);

        // CNT glitch: one clk_en cycle low with sp_in high.
        irq_base = irq_cnt;
        sp_in  = 1'b1;
        tick(4);
        cnt_in = 1'b0;
        tick(1);
        cnt_in = 1'b1;
        tick(8);
        check("glitch_no_irq", 32'(irq_cnt - irq_base), 32'd0);
`ifdef CIA_SP_CNT_FILTER_EN
        send_bits(8'h33, 8);
        check("glitch_byte", 32'(sdr_dout), 32'h33);
`else
        // The glitch counted as one bit of value 1, so 7 pulses finish a byte.
        send_bits(8'h33, 7);
        check("glitch_byte", 32'(sdr_dout), 32'hB3);
`endif
        check("glitch_irq", 32'(irq_cnt - irq_base), 32'd1);

        // ---------------- output mode, single byte ----------------
        sp_mode = SP_MODE_OUT;
        tick(2);
        underflow(2);
        check("out_idle_no_pending", 32'(busy), 32'h0);
        write_sdr(8'h3C);
        irq_base  = irq_cnt;
        rise_base = rise_cnt;
        underflow(1);
        check("out_busy_start", 32'(busy),    32'h1);
        check("out_cnt_low",    32'(cnt_out), 32'h0);
        underflow(15);
        check("out_rises_3c", 32'(rise_cnt - rise_base), 32'd8);
        check("out_bits_3c",  32'(rx_bits[7:0]),         32'h3C);
        check("out_irq_3c",   32'(irq_cnt - irq_base),   32'd1);
        check("out_busy_end", 32'(busy),                 32'h0);
        check("out_cnt_high", 32'(cnt_out),              32'h1);

        // ---------------- back-to-back 0x81 then 0x7E ----------------
        write_sdr(8'h81);
        irq_base  = irq_cnt;
        rise_base = rise_cnt;
        underflow(3);
        write_sdr(8'h7E);
        underflow(29);
        check("b2b_rises", 32'(rise_cnt - rise_base), 32'd16);
        check("b2b_bits",  32'(rx_bits),              32'h817E);
        check("b2b_irq",   32'(irq_cnt - irq_base),   32'd2);
        check("b2b_busy",  32'(busy),                 32'h0);

        // ---------------- write in the same cycle as the load ----------------
        write_sdr(8'h55);
        irq_base  = irq_cnt;
        rise_base = rise_cnt;
        sdr_wr       = 1'b1;
        sdr_din      = 8'hAA;
        ta_underflow = 1'b1;
        tick(1);
        sdr_wr       = 1'b0;
        ta_underflow = 1'b0;
        tick(1);
        check("wrload_sdr", 32'(sdr_dout), 32'hAA);
        underflow(31);
        check("wrload_rises", 32'(rise_cnt - rise_base), 32'd16);
        check("wrload_bits",  32'(rx_bits),              32'h55AA);
        check("wrload_irq",   32'(irq_cnt - irq_base),   32'd2);

        // ---------------- mode change abort ----------------
        write_sdr(8'hFF);
        irq_base = irq_cnt;
        underflow(5);
        check("abort_busy_before", 32'(busy),    32'h1);
        check("abort_cnt_before",  32'(cnt_out), 32'h0);
        sp_mode = SP_MODE_IN;
        tick(1);
        check("abort_cnt_out", 32'(cnt_out), 32'h1);
        check("abort_sp_out",  32'(sp_out),  32'h1);
        check("abort_busy",    32'(busy),    32'h0);
        tick(3);
        sp_mode = SP_MODE_OUT;
        tick(2);
        underflow(1);
        check("abort_stays_idle", 32'(busy),    32'h0);
        check("abort_cnt_idle",   32'(cnt_out), 32'h1);
        tick(4);
        check("abort_no_irq",   32'(irq_cnt - irq_base), 32'd0);
        check("abort_sdr_kept", 32'(sdr_dout),           32'hFF);

        // ---------------- reset mid-transfer, clk_en low ----------------
        write_sdr(8'h3C);
        underflow(3);
        check("rst_mid_busy_before", 32'(busy),             32'h1);
        check("rst_mid_pins_before", 32'({sp_out, cnt_out}), 32'h0);
        irq_base = irq_cnt;
        clk_en = 1'b0;
        reset  = 1'b1;
        tick(1);
        check("rst_mid_cnt_out", 32'(cnt_out),  32'h1);
        check("rst_mid_sp_out",  32'(sp_out),   32'h1);
        check("rst_mid_busy",    32'(busy),     32'h0);
        check("rst_mid_sdr",     32'(sdr_dout), 32'h00);
        check("rst_mid_irq",     32'(sp_irq),   32'h0);
        tick(1);
        reset  = 1'b0;
        clk_en = 1'b1;
        tick(2);
        underflow(1);
        check("rst_mid_no_pending", 32'(busy),               32'h0);
        check("rst_mid_no_irq",     32'(irq_cnt - irq_base), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
